// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions used by the fetch stage.
package riscv_pkg;

    // addi x0, x0, 0: the canonical bubble instruction
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } fetch_state_t;

    // Sequential next PC; wraps modulo 2^32 without any flag
    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: instruction, PC and valid bit handed to decode.
// flush has priority over en and loads a NOP bubble.
module if_id_reg
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] inst_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            valid_i,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] pc_o,
    output logic            valid_o
);

    logic [XLEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;

    // Next-state: flush to NOP, load when enabled, otherwise hold
    always_comb begin
        inst_d  = inst_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (flush_i) begin
            inst_d  = NOP_INSTR;
            pc_d    = '0;
            valid_d = 1'b0;
        end else if (en_i) begin
            inst_d  = inst_i;
            pc_d    = pc_i;
            valid_d = valid_i;
        end
    end

    // State registers with asynchronous reset to the bubble value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_q  <= NOP_INSTR;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            inst_q  <= inst_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign inst_o  = inst_q;
    assign pc_o    = pc_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch stage: PC, single-outstanding imem handshake and
// the IF/ID register. Defining FETCH_PERF_CNT_EN adds fetch/bubble counters.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int unsigned      XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_f,
    input  logic            stall_d,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] inst_d,
    output logic [XLEN-1:0] pc_d,
    output logic            valid_d
`ifdef FETCH_PERF_CNT_EN
   ,output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_bubble_cnt
`endif
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_f_q, pc_f_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic            kill_q, kill_d;
    logic [XLEN-1:0] buf_inst_q, buf_inst_d;
    logic            buf_valid_q, buf_valid_d;
    logic            imem_req_q, imem_req_d;

    logic            ifid_en;
    logic [XLEN-1:0] ifid_inst;
    logic [XLEN-1:0] ifid_pc;
    logic            ifid_valid;

    assign ifid_en = !stall_d || br_taken;

    // Next-state for FSM, PC, request address, kill flag and stall buffer
    always_comb begin
        state_d     = state_q;
        pc_f_d      = pc_f_q;
        req_addr_d  = req_addr_q;
        kill_d      = kill_q;
        buf_inst_d  = buf_inst_q;
        buf_valid_d = buf_valid_q;
        ifid_inst   = NOP_INSTR;
        ifid_pc     = '0;
        ifid_valid  = 1'b0;

        unique case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (imem_gnt) begin
                    state_d = WAIT;
                    // A killed request was for a stale address; PC already
                    // points at the redirect target, so do not advance it.
                    if (!kill_q) begin
                        pc_f_d = seq_pc(pc_f_q);
                    end
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = REQ;
                    end else if (!stall_d) begin
                        ifid_inst  = imem_rdata;
                        ifid_pc    = req_addr_q;
                        ifid_valid = 1'b1;
                        state_d    = stall_f ? HOLD : REQ;
                    end else begin
                        buf_inst_d  = imem_rdata;
                        buf_valid_d = 1'b1;
                        state_d     = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!stall_d) begin
                    // req_addr is not recaptured until REQ, so it is still
                    // the PC of the buffered word.
                    if (buf_valid_q) begin
                        ifid_inst  = buf_inst_q;
                        ifid_pc    = req_addr_q;
                        ifid_valid = 1'b1;
                    end
                    buf_valid_d = 1'b0;
                    if (!stall_f) begin
                        state_d = REQ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Redirect overrides stalls and any in-flight response
        if (br_taken) begin
            pc_f_d      = br_target;
            buf_valid_d = 1'b0;
            if (state_q == REQ) begin
                kill_d = 1'b1;
            end else if (state_q == WAIT) begin
                if (imem_rvalid) begin
                    kill_d  = 1'b0;
                    state_d = REQ;
                end else begin
                    kill_d = 1'b1;
                end
            end else if (state_q == HOLD) begin
                state_d = REQ;
            end
        end

        // Capture the fetch address only on entry to REQ so it stays stable
        if (state_d == REQ && state_q != REQ) begin
            req_addr_d = pc_f_d;
        end
    end

    assign imem_req_d = (state_d == REQ);

    // FSM and fetch-side state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_f_q      <= RESET_PC;
            req_addr_q  <= RESET_PC;
            kill_q      <= 1'b0;
            buf_inst_q  <= NOP_INSTR;
            buf_valid_q <= 1'b0;
            imem_req_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_f_q      <= pc_f_d;
            req_addr_q  <= req_addr_d;
            kill_q      <= kill_d;
            buf_inst_q  <= buf_inst_d;
            buf_valid_q <= buf_valid_d;
            imem_req_q  <= imem_req_d;
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = req_addr_q;

    if_id_reg #(
        .XLEN (XLEN)
    ) u_if_id_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (ifid_en),
        .flush_i (br_taken),
        .inst_i  (ifid_inst),
        .pc_i    (ifid_pc),
        .valid_i (ifid_valid),
        .inst_o  (inst_d),
        .pc_o    (pc_d),
        .valid_o (valid_d)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    // Classify every IF/ID load as a real instruction or a bubble
    always_comb begin
        fetch_cnt_d  = fetch_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (ifid_en) begin
            if (ifid_valid && !br_taken) begin
                fetch_cnt_d = fetch_cnt_q + 32'd1;
            end else begin
                bubble_cnt_d = bubble_cnt_q + 32'd1;
            end
        end
    end

    // Counter registers, free-running and wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign perf_fetch_cnt  = fetch_cnt_q;
    assign perf_bubble_cnt = bubble_cnt_q;
`endif

endmodule
